voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter N, default 8: number of voices; legal range 2..75.
REQ-002 Parameter AGE_W, default 8: width of each voice's age counter.
REQ-003 MHz10  input  1  system clock; all state updates on its rising edge.
REQ-004 nrst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  chip enable; when low, state is held and all inputs are ignored.
REQ-006 clear  input  1  synchronous flush of all voices.
REQ-007 note_on  input  1  single-cycle note-on request.
REQ-008 note_off  input  1  single-cycle note-off request.
REQ-009 note  input  7  MIDI note number, qualified by note_on or note_off.
REQ-010 velocity  input  7  MIDI velocity, qualified by note_on.
REQ-011 sustain  input  1  level input; high while the sustain pedal is down.
REQ-012 voice_active  output  N  per-voice gate; high while the voice is sounding.
REQ-013 voice_start  output  N  per-voice single-cycle (re)trigger pulse; one-hot or zero.
REQ-014 voice_release  output  N  per-voice single-cycle release pulse.
REQ-015 voice_note  output  N*7  per-voice note number, packed with voice i at [i*7+:7].
REQ-016 voice_vel  output  N*7  per-voice velocity, packed with voice i at [i*7+:7].
REQ-017 stolen  output  1  single-cycle pulse indicating that an active voice was reassigned.
REQ-018 dropped  output  1  single-cycle pulse indicating that a note_off was discarded.

Function
REQ-019 Each voice shall hold registered state: active, held, sustained, note[6:0], vel[6:0] and age[AGE_W-1:0].
REQ-020 All outputs shall be registered; every pulse response shall appear exactly 1 cycle after the qualifying input cycle.
REQ-021 note_on with velocity==0 shall be treated exactly as note_off.
REQ-022 note_on allocation priority: (a) an active voice with the same note is retriggered in place; (b) otherwise the lowest-index inactive voice is used; (c) otherwise the voice with the largest age is stolen, with ties going to the lowest index.
REQ-023 The allocated voice shall have note and vel loaded, active=1, held=1, sustained=0 and age=0, and its voice_start bit shall pulse.
REQ-024 stolen shall pulse only for case (c); a steal shall not pulse voice_release.
REQ-025 On each accepted note_on, every other active voice's age shall increment by 1, saturating at 2^AGE_W-1.
REQ-026 note_off shall match the lowest-index voice with held=1 and the same note; if no voice matches, note_off shall be ignored silently.
REQ-027 A matched note_off with sustain=0 shall set active=0 and held=0 and pulse the voice's voice_release bit.
REQ-028 A matched note_off with sustain=1 shall set held=0 and sustained=1; the voice shall stay active.
REQ-029 A sustain falling edge, detected from a registered copy of sustain, shall deactivate every voice with sustained=1 and pulse all of their voice_release bits in the same cycle.
REQ-030 A note_on that retriggers a sustained voice shall clear its sustained flag.
REQ-031 If note_on and note_off are both asserted in one cycle, note_on shall be processed, note_off shall be discarded, and dropped shall pulse.
REQ-032 If a note_on arrives in the same cycle as a sustain falling edge, the releases shall be applied first; the freed voices shall then be eligible for allocation in that same cycle.
REQ-033 clear (with en=1) shall zero all voice state and the age counters, with no release pulses; clear shall take priority over every other input that cycle.
REQ-034 With en=0, no state shall change, all pulse outputs shall be 0, and voice_active/voice_note/voice_vel shall hold their values.
REQ-035 voice_note and voice_vel shall retain their last values after a voice deactivates.

Reset
REQ-036 While nrst=0, all voice state, age counters, the registered sustain copy and all outputs shall be 0.
REQ-037 Assertion of nrst mid-operation shall clear all outputs immediately, without emitting any pulses.
REQ-038 After release of nrst, the first note_on shall allocate voice 0.

Verification (N=4)
REQ-039 Four note_on events (notes 60,62,64,65; velocity 100) -> voice_start pulses 0001, 0010, 0100, 1000 in order; voice_active=1111; voice_note slots = 60,62,64,65.
REQ-040 A fifth note_on (note 67) -> voice 0 is stolen: voice_start=0001, stolen=1, voice_note[0]=67, no release pulse; a sixth note_on then steals voice 1.
REQ-041 note_on 60 followed by note_on 60 with velocity 50 -> both trigger voice 0, second write sets voice_vel[0]=50, voice_active=0001.
REQ-042 sustain=1, note_on 60, note_off 60 -> voice 0 stays active; sustain falls -> voice_release=0001 one cycle later, voice_active=0000.
REQ-043 note_on 60 and note_off 62 in the same cycle -> voice 0 starts and dropped=1; note_off 70 with no match -> no output change.
REQ-044 With 3 voices active: en=0 with note_on -> no change; then clear -> voice_active=0000 with no release pulses; nrst pulse mid-run -> all outputs 0.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Signal bundle between a note source (master) and the voice allocator (slave).
// N sets the width of the per-voice vectors and must match the allocator's N.
interface voice_allocator_if #(
  parameter int N = 8
);
  logic           en;
  logic           clear;
  logic           note_on;
  logic           note_off;
  logic [6:0]     note;
  logic [6:0]     velocity;
  logic           sustain;
  logic [N-1:0]   voice_active;
  logic [N-1:0]   voice_start;
  logic [N-1:0]   voice_release;
  logic [N*7-1:0] voice_note;
  logic [N*7-1:0] voice_vel;
  logic           stolen;
  logic           dropped;

  modport master (
    output en, clear, note_on, note_off, note, velocity, sustain,
    input  voice_active, voice_start, voice_release, voice_note, voice_vel,
           stolen, dropped
  );

  modport slave (
    input  en, clear, note_on, note_off, note, velocity, sustain,
    output voice_active, voice_start, voice_release, voice_note, voice_vel,
           stolen, dropped
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note on/off events onto N voices with
// retrigger, free-voice, and oldest-voice-steal allocation plus sustain pedal handling.
module voice_allocator #(
  parameter int N     = 8,
  parameter int AGE_W = 8
) (
  input  logic             MHz10,
  input  logic             nrst,
  voice_allocator_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [N-1:0]       r_active;
  logic [N-1:0]       r_held;
  logic [N-1:0]       r_sustained;
  logic [6:0]         r_note [N];
  logic [6:0]         r_vel  [N];
  logic [AGE_W-1:0]   r_age  [N];
  logic               r_sustainQ;
  logic [N-1:0]       r_start;
  logic [N-1:0]       r_release;
  logic               r_stolen;
  logic               r_dropped;

  logic               w_fall;
  logic               w_onValid;
  logic               w_offValid;
  logic [N-1:0]       w_fallRelease;
  logic [N-1:0]       w_postActive;
  logic [N-1:0]       w_postSustained;

  logic               w_hitFound;
  logic               w_freeFound;
  logic               w_offFound;
  logic [IDX_W-1:0]   w_hitIdx;
  logic [IDX_W-1:0]   w_freeIdx;
  logic [IDX_W-1:0]   w_oldIdx;
  logic [IDX_W-1:0]   w_offIdx;
  logic [IDX_W-1:0]   w_target;
  logic [AGE_W-1:0]   w_oldAge;

  logic [N-1:0]       w_activeNxt;
  logic [N-1:0]       w_heldNxt;
  logic [N-1:0]       w_sustainedNxt;
  logic [6:0]         w_noteNxt [N];
  logic [6:0]         w_velNxt  [N];
  logic [AGE_W-1:0]   w_ageNxt  [N];
  logic [N-1:0]       w_startNxt;
  logic [N-1:0]       w_releaseNxt;
  logic               w_stolenNxt;
  logic               w_droppedNxt;

  // Pedal releases are applied before allocation so freed voices are reusable this cycle.
  always_comb begin
    w_fall          = r_sustainQ & ~bus.sustain;
    w_fallRelease   = w_fall ? r_sustained : '0;
    w_postActive    = r_active & ~w_fallRelease;
    w_postSustained = r_sustained & ~w_fallRelease;
    w_onValid       = bus.note_on & (bus.velocity != 7'd0);
    w_offValid      = (bus.note_on & (bus.velocity == 7'd0)) | (bus.note_off & ~bus.note_on);
  end

  always_comb begin
    w_hitFound  = 1'b0;
    w_freeFound = 1'b0;
    w_offFound  = 1'b0;
    w_hitIdx    = '0;
    w_freeIdx   = '0;
    w_offIdx    = '0;
    w_oldIdx    = '0;
    w_oldAge    = r_age[0];
    for (int i = 0; i < N; i++) begin
      if (!w_hitFound && w_postActive[i] && (r_note[i] == bus.note)) begin
        w_hitFound = 1'b1;
        w_hitIdx   = IDX_W'(i);
      end
      if (!w_freeFound && !w_postActive[i]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = IDX_W'(i);
      end
      if (!w_offFound && r_held[i] && (r_note[i] == bus.note)) begin
        w_offFound = 1'b1;
        w_offIdx   = IDX_W'(i);
      end
      // Strict compare keeps the lowest index on equal ages.
      if (r_age[i] > w_oldAge) begin
        w_oldAge = r_age[i];
        w_oldIdx = IDX_W'(i);
      end
    end
    w_target = w_hitFound ? w_hitIdx : (w_freeFound ? w_freeIdx : w_oldIdx);
  end

  always_comb begin
    w_activeNxt    = w_postActive;
    w_heldNxt      = r_held;
    w_sustainedNxt = w_postSustained;
    w_startNxt     = '0;
    w_releaseNxt   = w_fallRelease;
    w_stolenNxt    = w_onValid & ~w_hitFound & ~w_freeFound;
    w_droppedNxt   = bus.note_on & bus.note_off;
    for (int i = 0; i < N; i++) begin
      w_noteNxt[i] = r_note[i];
      w_velNxt[i]  = r_vel[i];
      w_ageNxt[i]  = r_age[i];
    end

    if (w_onValid) begin
      for (int i = 0; i < N; i++) begin
        if (IDX_W'(i) == w_target) begin
          w_activeNxt[i]    = 1'b1;
          w_heldNxt[i]      = 1'b1;
          w_sustainedNxt[i] = 1'b0;
          w_noteNxt[i]      = bus.note;
          w_velNxt[i]       = bus.velocity;
          w_ageNxt[i]       = '0;
          w_startNxt[i]     = 1'b1;
        end else if (w_postActive[i] && (r_age[i] != AGE_MAX)) begin
          w_ageNxt[i] = r_age[i] + 1'b1;
        end
      end
    end else if (w_offValid && w_offFound) begin
      for (int i = 0; i < N; i++) begin
        if (IDX_W'(i) == w_offIdx) begin
          w_heldNxt[i] = 1'b0;
          if (bus.sustain) begin
            w_sustainedNxt[i] = 1'b1;
          end else begin
            w_activeNxt[i]  = 1'b0;
            w_releaseNxt[i] = 1'b1;
          end
        end
      end
    end

    if (bus.clear) begin
      w_activeNxt    = '0;
      w_heldNxt      = '0;
      w_sustainedNxt = '0;
      w_startNxt     = '0;
      w_releaseNxt   = '0;
      w_stolenNxt    = 1'b0;
      w_droppedNxt   = 1'b0;
      for (int i = 0; i < N; i++) begin
        w_noteNxt[i] = '0;
        w_velNxt[i]  = '0;
        w_ageNxt[i]  = '0;
      end
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      r_active    <= '0;
      r_held      <= '0;
      r_sustained <= '0;
      r_sustainQ  <= 1'b0;
      r_start     <= '0;
      r_release   <= '0;
      r_stolen    <= 1'b0;
      r_dropped   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_age[i]  <= '0;
      end
    end else if (bus.en) begin
      r_active    <= w_activeNxt;
      r_held      <= w_heldNxt;
      r_sustained <= w_sustainedNxt;
      r_sustainQ  <= bus.sustain;
      r_start     <= w_startNxt;
      r_release   <= w_releaseNxt;
      r_stolen    <= w_stolenNxt;
      r_dropped   <= w_droppedNxt;
      for (int i = 0; i < N; i++) begin
        r_note[i] <= w_noteNxt[i];
        r_vel[i]  <= w_velNxt[i];
        r_age[i]  <= w_ageNxt[i];
      end
    end else begin
      r_start   <= '0;
      r_release <= '0;
      r_stolen  <= 1'b0;
      r_dropped <= 1'b0;
    end
  end

  assign bus.voice_active  = r_active;
  assign bus.voice_start   = r_start;
  assign bus.voice_release = r_release;
  assign bus.stolen        = r_stolen;
  assign bus.dropped       = r_dropped;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.voice_note[g*7 +: 7] = r_note[g];
    assign bus.voice_vel[g*7 +: 7]  = r_vel[g];
  end
endmodule
